// File: rtl/jtbubl_pkg.sv
// Shared constants for the Bubble Bobble SDRAM slot arbiter: slot count,
// FSM state encoding, slot indices and the round-robin pick helper.
package jtbubl_pkg;

    localparam int SLOTS = 5;

    // Arbiter FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Slot indices
    localparam logic [2:0] SLOT_MAIN  = 3'd0;
    localparam logic [2:0] SLOT_SUB   = 3'd1;
    localparam logic [2:0] SLOT_MCU   = 3'd2;
    localparam logic [2:0] SLOT_SOUND = 3'd3;
    localparam logic [2:0] SLOT_GFX   = 3'd4;

    // First pending slot strictly after 'last', wrapping 4 -> 0.
    // Scanning from the farthest candidate down lets the nearest one win.
    function automatic logic [2:0] rr_pick(input logic [SLOTS-1:0] pend,
                                           input logic [2:0]       last);
        logic [2:0] pick;
        logic [3:0] idx;
        pick = last;
        for (int k = SLOTS; k >= 1; k--) begin
            idx = {1'b0, last} + 4'(k);
            if (idx >= 4'd5) begin
                idx = idx - 4'd5;
            end else begin
                idx = idx;
            end
            if (pend[idx[2:0]]) begin
                pick = idx[2:0];
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/jtbubl_slot_cache.sv
// One-entry read cache for a single SDRAM slot: valid bit, tag and data word,
// plus the combinational hit compare against the slot's current address.
module jtbubl_slot_cache #(
    parameter int AW = 22
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic          hit,
    output logic [31:0]   data
);

    logic          valid_r;
    logic [AW-1:0] tag_r;
    logic [31:0]   data_r;

    // Valid bit: clear has priority so a fill during download stays invalid
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_r <= 1'b0;
        end else if (clr) begin
            valid_r <= 1'b0;
        end else if (we) begin
            valid_r <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data capture on every fill
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_r  <= '0;
            data_r <= 32'd0;
        end else if (we) begin
            tag_r  <= wr_addr;
            data_r <= wr_data;
        end else begin
            tag_r  <= tag_r;
            data_r <= data_r;
        end
    end

    assign hit  = valid_r & (tag_r == rd_addr);
    assign data = data_r;

endmodule

// File: rtl/jtbubl_slot_arb.sv
// Five-slot SDRAM read arbiter with one-entry caches per slot, round-robin
// grants, download invalidation, refresh window and CPU start gating.
module jtbubl_slot_arb
    import jtbubl_pkg::*;
#(
    parameter int         AW         = 22,
    parameter logic [4:0] START_MASK = 5'b01111
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          downloading,
    input  logic          slot0_cs,
    input  logic          slot1_cs,
    input  logic          slot2_cs,
    input  logic          slot3_cs,
    input  logic          slot4_cs,
    input  logic [AW-1:0] slot0_addr,
    input  logic [AW-1:0] slot1_addr,
    input  logic [AW-1:0] slot2_addr,
    input  logic [AW-1:0] slot3_addr,
    input  logic [AW-1:0] slot4_addr,
    output logic          slot0_ok,
    output logic          slot1_ok,
    output logic          slot2_ok,
    output logic          slot3_ok,
    output logic          slot4_ok,
    output logic [31:0]   slot0_dout,
    output logic [31:0]   slot1_dout,
    output logic [31:0]   slot2_dout,
    output logic [31:0]   slot3_dout,
    output logic [31:0]   slot4_dout,
    output logic          sdram_req,
    output logic [AW-1:0] sdram_addr,
    input  logic          sdram_ack,
    input  logic          data_rdy,
    input  logic [31:0]   data_read,
    output logic          refresh_en,
    output logic          cpu_start
);

    logic [1:0]       state_r;
    logic [2:0]       slot_r;
    logic [2:0]       ptr_r;
    logic             sdram_req_r;
    logic [AW-1:0]    sdram_addr_r;
    logic             cpu_start_r;
    logic             live_r;

    logic [SLOTS-1:0] cs_s;
    logic [SLOTS-1:0] hit_s;
    logic [SLOTS-1:0] ok_s;
    logic [SLOTS-1:0] pend_s;
    logic             any_pend_s;
    logic             fill_s;
    logic [2:0]       grant_s;
    logic [AW-1:0]    addr_s [SLOTS];
    logic [31:0]      data_s [SLOTS];

    // Gather the per-slot ports into indexable vectors
    always_comb begin
        cs_s      = {slot4_cs, slot3_cs, slot2_cs, slot1_cs, slot0_cs};
        addr_s[0] = slot0_addr;
        addr_s[1] = slot1_addr;
        addr_s[2] = slot2_addr;
        addr_s[3] = slot3_addr;
        addr_s[4] = slot4_addr;
    end

    // Miss detection, fill strobe and round-robin grant selection
    always_comb begin
        ok_s       = cs_s & hit_s;
        pend_s     = cs_s & ~hit_s & {SLOTS{~downloading}};
        any_pend_s = |pend_s;
        fill_s     = data_rdy & ((state_r == ST_WAIT) |
                                 ((state_r == ST_REQ) & sdram_ack));
        grant_s    = rr_pick(pend_s, ptr_r);
    end

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_cache
            jtbubl_slot_cache #(.AW(AW)) u_cache (
                .clk     (clk),
                .rstn    (rstn),
                .clr     (downloading),
                .we      (fill_s & (slot_r == 3'(gi))),
                .wr_addr (sdram_addr_r),
                .wr_data (data_read),
                .rd_addr (addr_s[gi]),
                .hit     (hit_s[gi]),
                .data    (data_s[gi])
            );
        end
    endgenerate

    // Arbiter FSM: grant in IDLE, hold request until ack, wait for data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            slot_r       <= 3'd0;
            ptr_r        <= 3'd4;
            sdram_req_r  <= 1'b0;
            sdram_addr_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_pend_s) begin
                        slot_r       <= grant_s;
                        sdram_addr_r <= addr_s[grant_s];
                        sdram_req_r  <= 1'b1;
                        state_r      <= ST_REQ;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) begin
                        sdram_req_r <= 1'b0;
                        if (data_rdy) begin
                            // ack and data together: treat as ack then data
                            ptr_r   <= slot_r;
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (data_rdy) begin
                        ptr_r   <= slot_r;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    sdram_req_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Marks the first clock after reset release; gates the refresh window
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            live_r <= 1'b0;
        end else begin
            live_r <= 1'b1;
        end
    end

    // Sticky CPU start once every required slot hits in the same cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cpu_start_r <= 1'b0;
        end else if (!downloading && ((ok_s & START_MASK) == START_MASK)) begin
            cpu_start_r <= 1'b1;
        end else begin
            cpu_start_r <= cpu_start_r;
        end
    end

    assign refresh_en = live_r & (state_r == ST_IDLE) & ~any_pend_s;
    assign cpu_start  = cpu_start_r;
    assign sdram_req  = sdram_req_r;
    assign sdram_addr = sdram_addr_r;

    assign slot0_ok   = ok_s[0];
    assign slot1_ok   = ok_s[1];
    assign slot2_ok   = ok_s[2];
    assign slot3_ok   = ok_s[3];
    assign slot4_ok   = ok_s[4];
    assign slot0_dout = data_s[0];
    assign slot1_dout = data_s[1];
    assign slot2_dout = data_s[2];
    assign slot3_dout = data_s[3];
    assign slot4_dout = data_s[4];

endmodule

// File: tb/tb_jtbubl_slot_arb.sv
// Directed testbench for jtbubl_slot_arb with hand-computed expectations.
module tb_jtbubl_slot_arb;

    localparam int AW = 22;

    logic          clk;
    logic          rstn;
    logic          downloading;
    logic          slot0_cs, slot1_cs, slot2_cs, slot3_cs, slot4_cs;
    logic [AW-1:0] slot0_addr, slot1_addr, slot2_addr, slot3_addr, slot4_addr;
    logic          slot0_ok, slot1_ok, slot2_ok, slot3_ok, slot4_ok;
    logic [31:0]   slot0_dout, slot1_dout, slot2_dout, slot3_dout, slot4_dout;
    logic          sdram_req;
    logic [AW-1:0] sdram_addr;
    logic          sdram_ack;
    logic          data_rdy;
    logic [31:0]   data_read;
    logic          refresh_en;
    logic          cpu_start;

    int errors = 0;
    int checks = 0;

    logic [4:0]    ok_v;
    logic [AW-1:0] a_seen;

    assign ok_v = {slot4_ok, slot3_ok, slot2_ok, slot1_ok, slot0_ok};

    jtbubl_slot_arb #(.AW(AW), .START_MASK(5'b01111)) dut (
        .clk(clk), .rstn(rstn), .downloading(downloading),
        .slot0_cs(slot0_cs), .slot1_cs(slot1_cs), .slot2_cs(slot2_cs),
        .slot3_cs(slot3_cs), .slot4_cs(slot4_cs),
        .slot0_addr(slot0_addr), .slot1_addr(slot1_addr), .slot2_addr(slot2_addr),
        .slot3_addr(slot3_addr), .slot4_addr(slot4_addr),
        .slot0_ok(slot0_ok), .slot1_ok(slot1_ok), .slot2_ok(slot2_ok),
        .slot3_ok(slot3_ok), .slot4_ok(slot4_ok),
        .slot0_dout(slot0_dout), .slot1_dout(slot1_dout), .slot2_dout(slot2_dout),
        .slot3_dout(slot3_dout), .slot4_dout(slot4_dout),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .data_rdy(data_rdy), .data_read(data_read),
        .refresh_en(refresh_en), .cpu_start(cpu_start)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request and report its address
    task automatic wait_req(output logic [AW-1:0] a);
        int n;
        n = 0;
        while (sdram_req !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("req_seen", {63'd0, sdram_req}, 64'd1);
        a = sdram_addr;
    endtask

    // Hold off ack for dly cycles, then pulse it
    task automatic do_ack(input int dly);
        for (int i = 0; i < dly; i++) begin
            step();
            chk("req_hold", {63'd0, sdram_req}, 64'd1);
        end
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        chk("req_drop", {63'd0, sdram_req}, 64'd0);
    endtask

    // Pulse data_rdy dly cycles after the ack
    task automatic do_rdy(input int dly, input logic [31:0] d);
        for (int i = 1; i < dly; i++) step();
        data_read = d;
        data_rdy  = 1'b1;
        step();
        data_rdy  = 1'b0;
        chk("spacing", {63'd0, sdram_req}, 64'd0);
    endtask

    task automatic serve(input logic [AW-1:0] exp_addr, input logic [31:0] d);
        wait_req(a_seen);
        chk("grant_addr", 64'(a_seen), 64'(exp_addr));
        do_ack(1);
        do_rdy(2, d);
    endtask

    initial begin
        rstn = 1'b0; downloading = 1'b0;
        {slot0_cs, slot1_cs, slot2_cs, slot3_cs, slot4_cs} = 5'd0;
        slot0_addr = '0; slot1_addr = '0; slot2_addr = '0; slot3_addr = '0; slot4_addr = '0;
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = 32'd0;

        // Reset state
        #12;
        chk("rst_req", {63'd0, sdram_req}, 64'd0);
        chk("rst_addr", 64'(sdram_addr), 64'd0);
        chk("rst_cpu", {63'd0, cpu_start}, 64'd0);
        chk("rst_ok", 64'(ok_v), 64'd0);
        chk("rst_refresh", {63'd0, refresh_en}, 64'd0);
        step();
        rstn = 1'b1;
        #1;
        chk("refresh_pre", {63'd0, refresh_en}, 64'd0);
        step();
        chk("refresh_idle", {63'd0, refresh_en}, 64'd1);

        // Single miss on slot 0
        slot0_cs = 1'b1; slot0_addr = 22'h00010;
        #1;
        chk("miss_ok", {63'd0, slot0_ok}, 64'd0);
        chk("miss_refresh", {63'd0, refresh_en}, 64'd0);
        wait_req(a_seen);
        chk("s0_addr", 64'(a_seen), 64'h10);
        do_ack(2);
        do_rdy(4, 32'hDEADBEEF);
        chk("s0_ok", {63'd0, slot0_ok}, 64'd1);
        chk("s0_dout", 64'(slot0_dout), 64'hDEADBEEF);
        step();
        chk("s0_noreq", {63'd0, sdram_req}, 64'd0);
        chk("s0_refresh", {63'd0, refresh_en}, 64'd1);

        // Round robin: 1,3,4 together, then 1 and 3 again
        slot1_cs = 1'b1; slot1_addr = 22'h200;
        slot3_cs = 1'b1; slot3_addr = 22'h300;
        slot4_cs = 1'b1; slot4_addr = 22'h400;
        serve(22'h200, 32'h1111_0001);
        serve(22'h300, 32'h3333_0001);
        serve(22'h400, 32'h4444_0001);
        chk("rr_ok", 64'(ok_v), 64'h1B);
        chk("rr_d4", 64'(slot4_dout), 64'h4444_0001);
        slot1_addr = 22'h204; slot3_addr = 22'h304;
        serve(22'h204, 32'h1111_0002);
        serve(22'h304, 32'h3333_0002);
        chk("rr_d1", 64'(slot1_dout), 64'h1111_0002);
        chk("rr_d3", 64'(slot3_dout), 64'h3333_0002);
        chk("cpu_not_yet", {63'd0, cpu_start}, 64'd0);

        // Address change on slot 2 while waiting for data
        slot2_cs = 1'b1; slot2_addr = 22'h100;
        wait_req(a_seen);
        chk("s2_addr", 64'(a_seen), 64'h100);
        do_ack(1);
        slot2_addr = 22'h104;
        do_rdy(3, 32'h2222_0100);
        chk("s2_stale_ok", {63'd0, slot2_ok}, 64'd0);
        chk("cpu_stale", {63'd0, cpu_start}, 64'd0);
        serve(22'h104, 32'h2222_0104);
        chk("s2_ok", {63'd0, slot2_ok}, 64'd1);
        chk("s2_dout", 64'(slot2_dout), 64'h2222_0104);
        chk("cpu_reg", {63'd0, cpu_start}, 64'd0);
        step();
        chk("cpu_set", {63'd0, cpu_start}, 64'd1);
        {slot0_cs, slot1_cs, slot2_cs, slot3_cs, slot4_cs} = 5'd0;
        step();
        chk("cpu_hold", {63'd0, cpu_start}, 64'd1);
        chk("drop_ok", 64'(ok_v), 64'd0);

        // Download during WAIT
        slot3_cs = 1'b1; slot3_addr = 22'h304;
        slot4_cs = 1'b1; slot4_addr = 22'h500;
        #1;
        chk("s3_hit", {63'd0, slot3_ok}, 64'd1);
        wait_req(a_seen);
        chk("dl_addr", 64'(a_seen), 64'h500);
        do_ack(1);
        downloading = 1'b1;
        do_rdy(2, 32'h5555_0500);
        chk("dl_s4_ok", {63'd0, slot4_ok}, 64'd0);
        chk("dl_s3_ok", {63'd0, slot3_ok}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dl_noreq", {63'd0, sdram_req}, 64'd0);
        end
        chk("dl_cpu", {63'd0, cpu_start}, 64'd1);
        slot3_cs = 1'b0;
        downloading = 1'b0;
        serve(22'h500, 32'h5555_0501);
        chk("dl_s4_fill", 64'(slot4_dout), 64'h5555_0501);
        chk("dl_s4_ok2", {63'd0, slot4_ok}, 64'd1);
        slot4_cs = 1'b0;

        // Ack and data_rdy together in REQ
        slot3_cs = 1'b1; slot3_addr = 22'h308;
        wait_req(a_seen);
        chk("both_addr", 64'(a_seen), 64'h308);
        sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'hCAFE_0308;
        step();
        sdram_ack = 1'b0; data_rdy = 1'b0;
        chk("both_ok", {63'd0, slot3_ok}, 64'd1);
        chk("both_dout", 64'(slot3_dout), 64'hCAFE_0308);
        chk("both_req", {63'd0, sdram_req}, 64'd0);

        // Asynchronous reset while in REQ
        slot1_cs = 1'b1; slot1_addr = 22'h999;
        wait_req(a_seen);
        chk("ar_ok_pre", {63'd0, slot3_ok}, 64'd1);
        rstn = 1'b0;
        #1;
        chk("ar_req", {63'd0, sdram_req}, 64'd0);
        chk("ar_ok", 64'(ok_v), 64'd0);
        chk("ar_cpu", {63'd0, cpu_start}, 64'd0);
        {slot0_cs, slot1_cs, slot2_cs, slot3_cs, slot4_cs} = 5'd0;
        step();
        rstn = 1'b1;
        sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'hBAD0_BAD0;
        step();
        sdram_ack = 1'b0; data_rdy = 1'b0;
        chk("late_req", {63'd0, sdram_req}, 64'd0);
        step();
        slot1_cs = 1'b1;
        #1;
        chk("late_ok", {63'd0, slot1_ok}, 64'd0);
        serve(22'h999, 32'h0000_0999);
        chk("post_rst_ok", {63'd0, slot1_ok}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
